// File: rtl/addr_bus_pkg.sv
// Shared types and helpers for the ABL/ABH address-bus control sequencer.
// Holds the FSM state encoding, vector-kind codes and the kind -> Z-mask map.
package addr_bus_pkg;

    typedef enum logic [2:0] {
        ST_RST_HOLD = 3'd0,
        ST_RST_WAIT = 3'd1,
        ST_IDLE     = 3'd2,
        ST_VEC_LO   = 3'd3,
        ST_VEC_HI   = 3'd4
    } state_t;

    localparam logic [1:0] VK_NMI = 2'd0;
    localparam logic [1:0] VK_RES = 2'd1;
    localparam logic [1:0] VK_IRQ = 2'd2;

    // ADL is all ones when not zeroed, so the mask is the inverse of the
    // vector address low bits: FFFA -> 101, FFFC -> 011, FFFE -> 001.
    function automatic logic [2:0] z_mask(input logic [1:0] kind);
        logic [2:0] mask;
        case (kind)
            VK_NMI:  mask = 3'b101;
            VK_RES:  mask = 3'b011;
            default: mask = 3'b001;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/addr_bus_rst_cnt.sv
// Post-reset delay counter: counts while enabled, flags the last delay cycle.
// Cleared by the synchronous active-low core reset.
module addr_bus_rst_cnt #(
    parameter int RST_DLY = 5,
    parameter int CNT_W   = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic done
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(RST_DLY - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign done = (cnt == LAST);

endmodule

// File: rtl/addr_bus_ctl.sv
// ABL/ABH load-enable and ADL zeroing sequencer for the 6502 address bus.
// Runs the post-reset delay and the two-cycle vector fetch on its own.
//
// state       | meaning
// ------------+-----------------------------------------------------
// RST_HOLD    | reset asserted or just released; all strobes low
// RST_WAIT    | dummy stack cycles, dispatcher loads pass through
// IDLE        | dispatcher drives ABL/ABH loads, vector requests accepted
// VEC_LO      | vector low byte address (FFFA/FFFC/FFFE) on the bus
// VEC_HI      | vector high byte address (low byte + 1) on the bus
module addr_bus_ctl
    import addr_bus_pkg::*;
#(
    parameter int RST_DLY = 5,
    parameter int CNT_W   = 3
) (
    input  logic       PHI0,
    input  logic       n_RES,
    input  logic       RDY,
    input  logic       ld_lo,
    input  logic       ld_hi,
    input  logic       vec_req,
    input  logic [1:0] vec_kind,
    output logic       ADL_ABL,
    output logic       ADH_ABH,
    output logic       Z_ADL0,
    output logic       Z_ADL1,
    output logic       Z_ADL2,
    output logic       ADH_FF,
    output logic       busy,
    output logic       vec_ack,
    output logic       vec_done
);

    state_t     state_q, state_d;
    logic [1:0] kind_q, kind_d;
    logic       cnt_done;
    logic [2:0] mask;

    addr_bus_rst_cnt #(
        .RST_DLY(RST_DLY),
        .CNT_W  (CNT_W)
    ) u_rst_cnt (
        .clk  (PHI0),
        .rst_n(n_RES),
        .en   (state_q == ST_RST_WAIT),
        .done (cnt_done)
    );

    always_ff @(posedge PHI0) begin
        if (!n_RES) begin
            state_q <= ST_RST_HOLD;
            kind_q  <= VK_RES;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        kind_d   = kind_q;
        mask     = z_mask(kind_q);
        ADL_ABL  = 1'b0;
        ADH_ABH  = 1'b0;
        Z_ADL0   = 1'b0;
        Z_ADL1   = 1'b0;
        Z_ADL2   = 1'b0;
        ADH_FF   = 1'b0;
        busy     = 1'b1;
        vec_ack  = 1'b0;
        vec_done = 1'b0;

        case (state_q)
            ST_RST_HOLD: begin
                state_d = ST_RST_WAIT;
            end
            ST_RST_WAIT: begin
                ADL_ABL = ld_lo;
                ADH_ABH = ld_hi;
                if (cnt_done) begin
                    state_d = ST_VEC_LO;
                    kind_d  = VK_RES;
                end
            end
            ST_IDLE: begin
                busy    = 1'b0;
                ADL_ABL = ld_lo;
                ADH_ABH = ld_hi;
                // An edge with reset asserted accepts nothing.
                vec_ack = vec_req & RDY & n_RES;
                if (vec_req && RDY) begin
                    state_d = ST_VEC_LO;
                    kind_d  = vec_kind;
                end
            end
            ST_VEC_LO: begin
                ADL_ABL                  = 1'b1;
                ADH_ABH                  = 1'b1;
                ADH_FF                   = 1'b1;
                {Z_ADL2, Z_ADL1, Z_ADL0} = mask;
                if (RDY) begin
                    state_d = ST_VEC_HI;
                end
            end
            ST_VEC_HI: begin
                ADL_ABL                  = 1'b1;
                ADH_ABH                  = 1'b1;
                ADH_FF                   = 1'b1;
                {Z_ADL2, Z_ADL1, Z_ADL0} = mask & 3'b110;
                // A reset at this edge abandons the fetch, so no done pulse.
                vec_done = RDY & n_RES;
                if (RDY) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_RST_HOLD;
            end
        endcase
    end

endmodule

// File: tb/tb_addr_bus_ctl.sv
// Self-checking bench for addr_bus_ctl: a directed vector table followed by
// randomized cycles, both checked against an address-queue reference model.
module tb_addr_bus_ctl;

    localparam int RST_DLY = 5;
    localparam int CNT_W   = 3;

    logic       PHI0 = 1'b0;
    logic       n_RES = 1'b0;
    logic       RDY = 1'b1;
    logic       ld_lo = 1'b0;
    logic       ld_hi = 1'b0;
    logic       vec_req = 1'b0;
    logic [1:0] vec_kind = 2'd0;
    logic       ADL_ABL, ADH_ABH, Z_ADL0, Z_ADL1, Z_ADL2;
    logic       ADH_FF, busy, vec_ack, vec_done;

    int checks = 0;
    int errors = 0;

    addr_bus_ctl #(
        .RST_DLY(RST_DLY),
        .CNT_W  (CNT_W)
    ) dut (
        .PHI0    (PHI0),
        .n_RES   (n_RES),
        .RDY     (RDY),
        .ld_lo   (ld_lo),
        .ld_hi   (ld_hi),
        .vec_req (vec_req),
        .vec_kind(vec_kind),
        .ADL_ABL (ADL_ABL),
        .ADH_ABH (ADH_ABH),
        .Z_ADL0  (Z_ADL0),
        .Z_ADL1  (Z_ADL1),
        .Z_ADL2  (Z_ADL2),
        .ADH_FF  (ADH_FF),
        .busy    (busy),
        .vec_ack (vec_ack),
        .vec_done(vec_done)
    );

    always #5 PHI0 = ~PHI0;

    // Output word: {ADL_ABL, ADH_ABH, Z2, Z1, Z0, ADH_FF, busy, vec_ack, vec_done}
    typedef struct packed {
        logic       n_res;
        logic       rdy;
        logic       lo;
        logic       hi;
        logic       req;
        logic [1:0] kind;
        logic [8:0] expect_out;
    } vec_t;

    vec_t tbl[$];

    // Reference model: the bus is either held in reset, counting dummy
    // cycles, emitting a queue of vector addresses, or free for the dispatcher.
    bit          m_hold = 1'b1;
    int          m_wait = 0;
    logic [15:0] m_q[$];

    function automatic logic [15:0] vec_base(input logic [1:0] k);
        case (k)
            2'd0:    return 16'hFFFA;
            2'd1:    return 16'hFFFC;
            default: return 16'hFFFE;
        endcase
    endfunction

    function automatic logic [8:0] model_out(input logic nr, input logic rdy,
                                             input logic lo, input logic hi,
                                             input logic req);
        logic [15:0] a;
        if (m_hold) return 9'b000000100;
        if (m_wait > 0) return {lo, hi, 3'b000, 1'b0, 1'b1, 2'b00};
        if (m_q.size() > 0) begin
            a = m_q[0];
            return {2'b11, ~a[2:0], 1'b1, 1'b1, 1'b0,
                    nr & rdy & (m_q.size() == 1)};
        end
        return {lo, hi, 3'b000, 1'b0, 1'b0, nr & req & rdy, 1'b0};
    endfunction

    task automatic model_edge(input logic nr, input logic rdy, input logic req,
                              input logic [1:0] k);
        logic [15:0] b;
        if (!nr) begin
            m_hold = 1'b1;
            m_wait = 0;
            m_q.delete();
        end else if (m_hold) begin
            m_hold = 1'b0;
            m_wait = RST_DLY;
        end else if (m_wait > 0) begin
            m_wait--;
            if (m_wait == 0) begin
                m_q.push_back(16'hFFFC);
                m_q.push_back(16'hFFFD);
            end
        end else if (m_q.size() > 0) begin
            if (rdy) void'(m_q.pop_front());
        end else if (req && rdy) begin
            b = vec_base(k);
            m_q.push_back(b);
            m_q.push_back(b + 16'd1);
        end
    endtask

    task automatic step(input logic nr, input logic rdy, input logic lo,
                        input logic hi, input logic req, input logic [1:0] k,
                        input bit use_tbl, input logic [8:0] tbl_exp,
                        input int idx);
        logic [8:0] act, mexp;
        @(negedge PHI0);
        n_RES    = nr;
        RDY      = rdy;
        ld_lo    = lo;
        ld_hi    = hi;
        vec_req  = req;
        vec_kind = k;
        #1;
        act  = {ADL_ABL, ADH_ABH, Z_ADL2, Z_ADL1, Z_ADL0, ADH_FF, busy,
                vec_ack, vec_done};
        mexp = model_out(nr, rdy, lo, hi, req);
        checks++;
        if (act !== mexp) begin
            errors++;
            $display("FAIL model[%0d]: got %b expected %b", idx, act, mexp);
        end
        if (use_tbl) begin
            checks++;
            if (act !== tbl_exp) begin
                errors++;
                $display("FAIL table[%0d]: got %b expected %b", idx, act, tbl_exp);
            end
        end
        @(posedge PHI0);
        model_edge(nr, rdy, req, k);
    endtask

    task automatic add(input logic nr, input logic rdy, input logic lo,
                       input logic hi, input logic req, input logic [1:0] k,
                       input logic [8:0] e);
        tbl.push_back('{nr, rdy, lo, hi, req, k, e});
    endtask

    initial begin
        // Reset held for 3 cycles, enables gated off
        add(0, 1, 1, 1, 0, 0, 9'b000000100);
        add(0, 1, 0, 0, 0, 0, 9'b000000100);
        add(0, 1, 0, 0, 1, 0, 9'b000000100);
        add(1, 1, 1, 0, 0, 0, 9'b000000100);
        // Five dummy cycles with pass-through, no ack while busy
        add(1, 1, 1, 0, 0, 0, 9'b100000100);
        add(1, 0, 0, 1, 0, 0, 9'b010000100);
        add(1, 1, 0, 0, 1, 0, 9'b000000100);
        add(1, 1, 0, 0, 0, 0, 9'b000000100);
        add(1, 1, 0, 0, 0, 0, 9'b000000100);
        // RES vector FFFC / FFFD
        add(1, 1, 0, 0, 0, 0, 9'b110111100);
        add(1, 1, 0, 0, 0, 0, 9'b110101101);
        // IDLE pass-through
        add(1, 1, 1, 0, 0, 0, 9'b100000000);
        add(1, 1, 1, 1, 0, 0, 9'b110000000);
        // NMI with stalls in both vector cycles
        add(1, 1, 0, 0, 1, 0, 9'b000000010);
        add(1, 0, 0, 0, 0, 0, 9'b111011100);
        add(1, 0, 0, 0, 0, 0, 9'b111011100);
        add(1, 1, 0, 0, 0, 0, 9'b111011100);
        add(1, 0, 0, 0, 0, 0, 9'b111001100);
        add(1, 1, 0, 0, 0, 0, 9'b111001101);
        // IRQ: not accepted while stalled, then held through the fetch
        add(1, 0, 0, 0, 1, 2, 9'b000000000);
        add(1, 1, 0, 0, 1, 2, 9'b000000010);
        add(1, 1, 1, 0, 1, 3, 9'b110011100);
        add(1, 1, 1, 0, 1, 3, 9'b110001101);
        // Back-to-back kind 3 acked in the first IDLE cycle
        add(1, 1, 1, 0, 1, 3, 9'b100000010);
        add(1, 1, 0, 0, 0, 0, 9'b110011100);
        // Reset during VEC_HI: no done, full sequence repeats
        add(0, 1, 0, 0, 0, 0, 9'b110001100);
        add(1, 1, 0, 0, 0, 0, 9'b000000100);
        for (int i = 0; i < RST_DLY; i++) add(1, 1, 0, 0, 0, 0, 9'b000000100);
        add(1, 1, 0, 0, 0, 0, 9'b110111100);
        add(1, 1, 0, 0, 0, 0, 9'b110101101);
        add(1, 1, 0, 0, 0, 0, 9'b000000000);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].n_res, tbl[i].rdy, tbl[i].lo, tbl[i].hi, tbl[i].req,
                 tbl[i].kind, 1'b1, tbl[i].expect_out, i);
        end

        for (int c = 0; c < 3000; c++) begin
            step(logic'($urandom_range(0, 99) > 1),
                 logic'($urandom_range(0, 3) != 0),
                 logic'($urandom_range(0, 1)),
                 logic'($urandom_range(0, 1)),
                 logic'($urandom_range(0, 2) != 0),
                 2'($urandom_range(0, 3)),
                 1'b0, 9'b0, c);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
